// File: rtl/contador_pkg.sv
// Shared defaults for the down-counter with a debounced push-button step input.
package contador_pkg;

    localparam int DEFAULT_WIDTH           = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int STABLE_CNT_W            = 8;

    // Reset count is all-ones; consumers slice the low WIDTH bits.
    localparam logic [31:0] RESET_COUNT = 32'hFFFF_FFFF;

endpackage

// File: rtl/click_debounce.sv
// Synchronises a bouncing push-button, debounces it and emits a one-cycle
// tick on every accepted press (accepted 0->1 transition).
module click_debounce
    import contador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic click,
    output logic tick
);

    localparam logic [STABLE_CNT_W-1:0] L_LAST_SAMPLE = STABLE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_accepted;
    logic                    r_accepted_d;
    logic                    r_tick;
    logic [STABLE_CNT_W-1:0] r_stable_cnt;

    // Synchroniser, stability counter, accepted level and registered rising-edge tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_accepted   <= 1'b0;
            r_accepted_d <= 1'b0;
            r_tick       <= 1'b0;
            r_stable_cnt <= {STABLE_CNT_W{1'b0}};
        end else begin
            r_sync1 <= click;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_accepted) begin
                if (r_stable_cnt == L_LAST_SAMPLE) begin
                    r_accepted   <= r_sync2;
                    r_stable_cnt <= {STABLE_CNT_W{1'b0}};
                end else begin
                    r_stable_cnt <= r_stable_cnt + STABLE_CNT_W'(1);
                end
            end else begin
                r_stable_cnt <= {STABLE_CNT_W{1'b0}};
            end
            r_accepted_d <= r_accepted;
            r_tick       <= r_accepted & ~r_accepted_d;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/contador_regressivo.sv
// Down-counter stepped by debounced button presses, with synchronous load,
// registered zero flag and a one-cycle borrow pulse on wrap from zero.
module contador_regressivo
    import contador_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             click,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] contagem,
    output logic             zero,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] L_RESET_COUNT = RESET_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_ZERO        = {WIDTH{1'b0}};

    logic             w_tick;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_next_borrow;
    logic [WIDTH-1:0] r_cnt;
    logic             r_zero;
    logic             r_borrow;

    click_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_click_debounce (
        .clk   (clk),
        .reset (reset),
        .click (click),
        .tick  (w_tick)
    );

    // Next-state selection: load wins over a coincident tick.
    always_comb begin
        w_next_cnt    = r_cnt;
        w_next_borrow = 1'b0;
        if (load) begin
            w_next_cnt = load_value;
        end else if (w_tick) begin
            if (r_cnt == L_ZERO) begin
                w_next_cnt    = L_RESET_COUNT;
                w_next_borrow = 1'b1;
            end else begin
                w_next_cnt = r_cnt - WIDTH'(1);
            end
        end else begin
            w_next_cnt = r_cnt;
        end
    end

    // Count register with zero decoded from the next state so it is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= L_RESET_COUNT;
            r_zero   <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_cnt    <= w_next_cnt;
            r_zero   <= (w_next_cnt == L_ZERO);
            r_borrow <= w_next_borrow;
        end
    end

    assign contagem = r_cnt;
    assign zero     = r_zero;
    assign borrow   = r_borrow;

endmodule

// File: tb/tb_contador_regressivo.sv
// Randomised scoreboard bench for contador_regressivo against a cycle model
// built from the press/debounce timing rules.
module tb_contador_regressivo;

    localparam int W    = 3;
    localparam int D    = 4;
    localparam int MODV = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         click;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] contagem;
    logic         zero;
    logic         borrow;

    typedef struct {
        int cnt;
        bit zero;
        bit borrow;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: click history, accepted level, run length, tick schedule.
    bit m_c1, m_c2, m_acc;
    int m_run, m_tick_edge, m_cnt, m_k;
    bit m_zero, m_borrow;

    contador_regressivo #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .click      (click),
        .load       (load),
        .load_value (load_value),
        .contagem   (contagem),
        .zero       (zero),
        .borrow     (borrow)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_c1 = 1'b0; m_c2 = 1'b0; m_acc = 1'b0;
        m_run = 0; m_tick_edge = -1; m_k = 0;
        m_cnt = MODV - 1; m_zero = 1'b0; m_borrow = 1'b0;
    endfunction

    // One rising edge: the debouncer sees click from two edges ago; an accepted
    // press steps the count two edges after acceptance.
    function automatic void model_edge(bit c, bit l, int v);
        bit s;
        s = m_c2;
        m_c2 = m_c1;
        m_c1 = c;
        if (s != m_acc) begin
            m_run++;
            if (m_run == D) begin
                m_acc = s;
                m_run = 0;
                if (s) m_tick_edge = m_k + 2;
            end
        end else begin
            m_run = 0;
        end
        if (l) begin
            m_cnt = v;
            m_borrow = 1'b0;
        end else if (m_k == m_tick_edge) begin
            m_borrow = (m_cnt == 0);
            m_cnt = (m_cnt + MODV - 1) % MODV;
        end else begin
            m_borrow = 1'b0;
        end
        m_zero = (m_cnt == 0);
        m_k++;
    endfunction

    function automatic bit next_is_tick();
        return (m_k == m_tick_edge);
    endfunction

    task automatic step(input bit c, input bit l, input int v);
        exp_t e;
        click = c;
        load = l;
        load_value = W'(v);
        @(posedge clk);
        model_edge(c, l, v);
        e.cnt = m_cnt; e.zero = m_zero; e.borrow = m_borrow;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (contagem !== W'(e.cnt) || zero !== e.zero || borrow !== e.borrow) begin
                errors++;
                $display("FAIL scoreboard t=%0t: contagem=%0d zero=%0b borrow=%0b expected contagem=%0d zero=%0b borrow=%0b",
                         $time, contagem, zero, borrow, e.cnt, e.zero, e.borrow);
            end
        end
    end

    initial begin
        int len;
        bit lvl;
        reset = 1'b1; click = 1'b0; load = 1'b0; load_value = '0;
        model_reset();
        #12;
        check("reset_contagem", int'(contagem), 7);
        check("reset_zero", int'(zero), 0);
        check("reset_borrow", int'(borrow), 0);
        @(negedge clk); #1;
        reset = 1'b0;

        // Single clean press held 20 cycles.
        repeat (20) step(1, 0, 0);
        check("first_press_count", int'(contagem), 6);
        repeat (20) step(0, 0, 0);

        // Eight clean press/release pairs: walks down through zero and wraps.
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(D + 3, D + 10);
            repeat (len) step(1, 0, 0);
            len = $urandom_range(D + 3, D + 10);
            repeat (len) step(0, 0, 0);
        end

        // Bounce every 2 cycles: never stable long enough.
        for (int i = 0; i < 30; i++) step(((i / 2) % 2) == 0, 0, 0);
        repeat (10) step(0, 0, 0);

        // Random short glitches below the debounce length.
        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(1, D - 1);
            repeat (len) step(1, 0, 0);
            len = $urandom_range(1, 3);
            repeat (len) step(0, 0, 0);
        end
        repeat (10) step(0, 0, 0);

        // Load on exactly the edge the tick lands; the tick must be discarded.
        for (int i = 0; i < 6; i++) begin
            repeat (D + 8) step(1, next_is_tick(), int'($urandom_range(0, 7)));
            repeat (D + 6) step(0, 0, 0);
        end

        // Load 0 then press: zero flag, then wrap with borrow.
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        check("load0_zero", int'(zero), 1);
        repeat (D + 6) step(1, 0, 0);
        repeat (D + 6) step(0, 0, 0);
        check("after_load0_press", int'(contagem), 7);

        // Fully random click levels and occasional loads.
        lvl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++)
                step(lvl, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)));
        end
        repeat (D + 6) step(0, 0, 0);

        // Asynchronous reset mid-debounce with click held high.
        step(0, 1, 2);
        repeat (3) step(1, 0, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_reset_contagem", int'(contagem), 7);
        check("async_reset_zero", int'(zero), 0);
        check("async_reset_borrow", int'(borrow), 0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (D + 10) step(1, 0, 0);
        check("post_reset_press", int'(contagem), 6);
        repeat (D + 6) step(0, 0, 0);

        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_regressivo.md
CONTADOR_REGRESSIVO -- requirements
Module: contador_regressivo

Interface
REQ-001 Parameter WIDTH, default 3, counter width in bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples required before a click level change is accepted; legal range 1..255.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port click  input  1  raw push-button level, asynchronous to clk, may bounce.
REQ-006 Port load  input  1  synchronous load strobe, sampled on rising clk.
REQ-007 Port load_value  input  WIDTH  value written into contagem when load=1.
REQ-008 Port contagem  output  WIDTH  current count, registered.
REQ-009 Port zero  output  1  level, high while contagem == 0.
REQ-010 Port borrow  output  1  one-cycle pulse on wrap from 0 to all-ones.

Function
REQ-011 click shall pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: synchronized level differing from the accepted level shall increment a stability counter; any sample equal to the accepted level shall clear it; on reaching DEBOUNCE_CYCLES the accepted level shall take the new value and the counter shall clear.
REQ-013 A 0->1 transition of the accepted level shall produce exactly one internal tick of one clk cycle; 1->0 transitions shall produce no tick.
REQ-014 With click held stable high from before edge N, contagem shall change on rising edge N+DEBOUNCE_CYCLES+3 (2 sync, DEBOUNCE_CYCLES stability, 1 edge detect/register).
REQ-015 On tick with load=0, contagem shall decrement by 1 modulo 2^WIDTH.
REQ-016 On tick with contagem == 0, contagem shall become 2^WIDTH-1 and borrow shall be 1 for exactly the following cycle.
REQ-017 load=1 shall write load_value into contagem on that edge regardless of tick; a coincident tick shall be discarded, borrow shall stay 0.
REQ-018 zero shall be a registered-state decode: high in every cycle contagem == 0, including after load of 0.
REQ-019 Bounce shorter than DEBOUNCE_CYCLES samples shall cause no tick and no change of contagem.
REQ-020 Holding click high indefinitely shall produce a single tick; a new tick requires an accepted release followed by an accepted press.
REQ-021 No output shall depend combinationally on click, load or load_value.

Reset
REQ-022 reset=1 shall immediately, without clk, force contagem to all-ones (7 for WIDTH=3), zero=0, borrow=0.
REQ-023 reset shall clear synchronizer flops, accepted level, stability counter and edge-detect register to 0.
REQ-024 reset asserted mid-debounce or mid-press shall discard the pending event; after deassertion a press still held high shall be treated as a new press and produce one tick.

Structure
REQ-025 Package contador_pkg shall hold default WIDTH, default DEBOUNCE_CYCLES and the reset count constant (all-ones).
REQ-026 Synchronizer, debounce and edge detect shall be one sub-module, click_debounce, outputting the one-cycle tick; contador_regressivo shall instantiate it once and hold the counter, load, zero and borrow logic.

Verification
REQ-027 Reset, then clean click press held 20 cycles (DEBOUNCE_CYCLES=4) -> contagem 7->6 exactly on edge 7 after press, single step, zero=0.
REQ-028 From reset, 7 clean press/release pairs -> contagem 6,5,4,3,2,1,0, zero=1 after last; 8th press -> contagem=7, borrow high one cycle, zero=0.
REQ-029 Click toggling every 2 cycles for 30 cycles then low -> contagem remains 7, no tick, borrow never high.
REQ-030 load=1 load_value=3 on same edge tick fires -> contagem=3, not 2; next press -> 2.
REQ-031 Load 0 then press -> zero=1 after load, then contagem=7, borrow pulse, zero=0.
REQ-032 reset asserted asynchronously between clk edges mid-debounce with click high -> contagem=7 immediately; after release of reset with click still high -> exactly one tick, contagem=6.
